// File: rtl/exp_gpio_cond.sv
// exp_gpio_cond: expansion pad conditioning
// sync, debounce, edge detect, sticky flags
module exp_gpio_cond #(
  parameter int            DW      = 8,
  parameter int            CW      = 16,
  parameter logic [CW-1:0] DEB_RST = 16'd1000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] gpio_i,
  output logic [DW-1:0] gpio_o,
  output logic [DW-1:0] rise_o,
  output logic [DW-1:0] fall_o,
  output logic          irq_o,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack
);

  logic [DW-1:0]   s1;
  logic [DW-1:0]   s2;
  logic [CW-1:0]   cnt [DW];
  logic [CW-1:0]   thr;
  logic [DW-1:0]   rise_en;
  logic [DW-1:0]   fall_en;
  logic [2*DW-1:0] irq_en;
  logic [2*DW-1:0] status;
  logic [DW-1:0]   flip;
  logic [2*DW-1:0] sts_set;
  logic [2*DW-1:0] sts_clr;
  logic [31:0]     rd_mux;
  logic [19:0]     addr;
  logic            unused_ok;

  assign addr      = sys_addr[19:0];
  assign sys_err   = 1'b0;
  assign unused_ok = ^{sys_addr[31:20], sys_wdata};

  // per-bit: disagreement has lasted long enough
  always_comb begin
    flip = '0;
    for (int i = 0; i < DW; i++)
      flip[i] = (s2[i] != gpio_o[i]) && (cnt[i] >= thr);
  end

  // two-flop synchroniser
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gpio_i;
      s2 <= s1;
    end
  end

  // debounce counters, level and edge pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < DW; i++)
        cnt[i] <= '0;
    end else begin
      rise_o <= flip & s2;
      fall_o <= flip & ~s2;
      for (int i = 0; i < DW; i++) begin
        if (flip[i])
          gpio_o[i] <= s2[i];
        if (s2[i] == gpio_o[i] || flip[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign sts_set = {fall_o & fall_en, rise_o & rise_en};
  assign sts_clr = (sys_wen && addr == 20'h0C) ?
                   sys_wdata[2*DW-1:0] : '0;

  // control registers, sticky status, interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      thr     <= DEB_RST;
      rise_en <= '0;
      fall_en <= '0;
      irq_en  <= '0;
      status  <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (sys_wen) begin
        unique case (addr)
          20'h00:  thr     <= sys_wdata[CW-1:0];
          20'h04:  rise_en <= sys_wdata[DW-1:0];
          20'h08:  fall_en <= sys_wdata[DW-1:0];
          20'h10:  irq_en  <= sys_wdata[2*DW-1:0];
          default: ;
        endcase
      end
      status <= (status & ~sts_clr) | sts_set;
      irq_o  <= |(status & irq_en);
    end
  end

  // read decode
  always_comb begin
    rd_mux = '0;
    unique case (addr)
      20'h00:  rd_mux[CW-1:0]   = thr;
      20'h04:  rd_mux[DW-1:0]   = rise_en;
      20'h08:  rd_mux[DW-1:0]   = fall_en;
      20'h0C:  rd_mux[2*DW-1:0] = status;
      20'h10:  rd_mux[2*DW-1:0] = irq_en;
      20'h14:  rd_mux[DW-1:0]   = s2;
      20'h18:  rd_mux[DW-1:0]   = gpio_o;
      default: rd_mux = '0;
    endcase
  end

  // bus response, one cycle after request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_exp_gpio_cond.sv
// tb_exp_gpio_cond: randomized bench with
// behavioural model plus directed pins
module tb_exp_gpio_cond;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o, rise_o, fall_o;
  logic        irq_o;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic        sys_wen, sys_ren, sys_err, sys_ack;

  exp_gpio_cond dut (
    .clk_i(clk_i), .rst_i(rst_i), .gpio_i(gpio_i),
    .gpio_o(gpio_o), .rise_o(rise_o), .fall_o(fall_o),
    .irq_o(irq_o), .sys_addr(sys_addr),
    .sys_wdata(sys_wdata), .sys_wen(sys_wen),
    .sys_ren(sys_ren), .sys_rdata(sys_rdata),
    .sys_err(sys_err), .sys_ack(sys_ack)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural model state
  logic [7:0]  m_s1, m_s2, m_out, m_rise, m_fall;
  int          m_run [8];
  logic [15:0] m_thr;
  logic [7:0]  m_ren, m_fen;
  logic [15:0] m_ien, m_sts;
  logic        m_irq, m_ack;
  logic [31:0] m_rd;

  // model: run-length of pad/level disagreement
  always @(posedge clk_i) begin : model
    logic [19:0] a;
    logic [31:0] rd;
    logic [15:0] setv, clrv;
    a = sys_addr[19:0];
    if (rst_i) begin
      m_s1 = 0; m_s2 = 0; m_out = 0;
      m_rise = 0; m_fall = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_thr = 16'd1000; m_ren = 0; m_fen = 0;
      m_ien = 0; m_sts = 0; m_irq = 0;
      m_ack = 0; m_rd = 0;
    end else begin
      rd = 0;
      if (sys_ren)
        case (a)
          20'h00: rd = {16'h0, m_thr};
          20'h04: rd = {24'h0, m_ren};
          20'h08: rd = {24'h0, m_fen};
          20'h0C: rd = {16'h0, m_sts};
          20'h10: rd = {16'h0, m_ien};
          20'h14: rd = {24'h0, m_s2};
          20'h18: rd = {24'h0, m_out};
          default: rd = 0;
        endcase
      setv = {m_fall & m_fen, m_rise & m_ren};
      clrv = (sys_wen && a == 20'h0C) ?
             sys_wdata[15:0] : 16'h0;
      m_irq = |(m_sts & m_ien);
      m_sts = (m_sts & ~clrv) | setv;
      for (int i = 0; i < 8; i++) begin
        m_rise[i] = 0; m_fall[i] = 0;
        if (m_s2[i] == m_out[i]) m_run[i] = 0;
        else if (m_run[i] >= int'(m_thr)) begin
          m_out[i] = m_s2[i];
          m_rise[i] = m_s2[i];
          m_fall[i] = ~m_s2[i];
          m_run[i] = 0;
        end else m_run[i]++;
      end
      m_s2 = m_s1;
      m_s1 = gpio_i;
      if (sys_wen)
        case (a)
          20'h00: m_thr = sys_wdata[15:0];
          20'h04: m_ren = sys_wdata[7:0];
          20'h08: m_fen = sys_wdata[7:0];
          20'h10: m_ien = sys_wdata[15:0];
          default: ;
        endcase
      m_ack = sys_wen | sys_ren;
      m_rd = rd;
    end
  end

  // compare DUT against model every cycle
  always @(negedge clk_i) begin
    if (started) begin
      chk("gpio_o", gpio_o, m_out);
      chk("rise_o", rise_o, m_rise);
      chk("fall_o", fall_o, m_fall);
      chk("irq_o", irq_o, m_irq);
      chk("ack", sys_ack, m_ack);
      chk("err", sys_err, 0);
      if (m_ack) chk("rdata", sys_rdata, m_rd);
    end
  end

  task automatic edges(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [19:0] a,
                    input logic [31:0] d);
    @(negedge clk_i);
    sys_addr = {12'h0, a}; sys_wdata = d;
    sys_wen = 1;
    @(negedge clk_i);
    sys_wen = 0;
  endtask

  task automatic rd(input logic [19:0] a,
                    output logic [31:0] d);
    @(negedge clk_i);
    sys_addr = {12'h0, a}; sys_ren = 1;
    @(posedge clk_i); #1;
    chk("rd_ack", sys_ack, 1);
    d = sys_rdata;
    @(negedge clk_i);
    sys_ren = 0;
  endtask

  logic [31:0] v;
  int          r;
  logic [19:0] alist [9] = '{20'h00, 20'h04, 20'h08,
    20'h0C, 20'h10, 20'h14, 20'h18, 20'h7C, 20'h20};

  initial begin
    rst_i = 1; gpio_i = 0;
    sys_addr = 0; sys_wdata = 0;
    sys_wen = 0; sys_ren = 0;
    @(posedge clk_i);
    started = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    chk("rst_gpio", gpio_o, 0);
    chk("rst_ack", sys_ack, 0);
    rd(20'h00, v); chk("thr_rst", v, 32'h3E8);
    rd(20'h7C, v); chk("unmapped", v, 0);
    chk("err", sys_err, 0);

    // minimum latency with thr=0
    wr(20'h00, 0);
    gpio_i[0] = 1;
    edges(2); chk("lat0_early", gpio_o[0], 0);
    edges(1); chk("lat0_gpio", gpio_o[0], 1);
    chk("lat0_rise", rise_o[0], 1);
    edges(1); chk("lat0_pulse1", rise_o[0], 0);
    rd(20'h18, v); chk("rd_level", v, 32'h01);

    // sticky flag and interrupt
    wr(20'h04, 32'h01); wr(20'h10, 32'h0001);
    gpio_i[0] = 0;
    repeat (6) @(negedge clk_i);
    gpio_i[0] = 1;
    edges(3); chk("rise_b0", rise_o[0], 1);
    edges(1); chk("irq_pre", irq_o, 0);
    edges(1); chk("irq_set", irq_o, 1);
    rd(20'h0C, v); chk("sts_set", v, 32'h1);
    wr(20'h0C, 32'h1);
    chk("irq_hold", irq_o, 1);
    edges(1); chk("irq_clr", irq_o, 0);
    rd(20'h0C, v); chk("sts_clr", v, 0);

    // set wins over same-cycle clear
    gpio_i[0] = 0;
    repeat (6) @(negedge clk_i);
    gpio_i[0] = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    sys_addr = 32'h0C; sys_wdata = 1; sys_wen = 1;
    @(negedge clk_i);
    sys_wen = 0;
    rd(20'h0C, v); chk("set_wins", v, 32'h1);
    wr(20'h0C, 32'h1);

    // glitch rejection and thr=10 latency
    wr(20'h00, 10);
    gpio_i[3] = 1;
    repeat (8) @(negedge clk_i);
    gpio_i[3] = 0;
    repeat (20) @(negedge clk_i);
    chk("glitch", gpio_o[3], 0);
    rd(20'h0C, v); chk("glitch_sts", v, 0);
    @(negedge clk_i);
    gpio_i[3] = 1;
    edges(12); chk("lat10_early", gpio_o[3], 0);
    edges(1); chk("lat10_gpio", gpio_o[3], 1);
    chk("lat10_rise", rise_o[3], 1);

    // lowering thr mid-count
    wr(20'h00, 1000);
    gpio_i[5] = 1;
    repeat (502) @(posedge clk_i);
    @(negedge clk_i);
    sys_addr = 32'h00; sys_wdata = 100; sys_wen = 1;
    @(posedge clk_i); #1;
    chk("thr_wr_edge", gpio_o[5], 0);
    @(negedge clk_i);
    sys_wen = 0;
    @(posedge clk_i); #1;
    chk("thr_lower", gpio_o[5], 1);
    chk("thr_lower_rise", rise_o[5], 1);

    // reset mid-count
    @(negedge clk_i);
    gpio_i[6] = 1;
    repeat (50) @(negedge clk_i);
    rst_i = 1;
    @(posedge clk_i); #1;
    chk("rst_mid_gpio", gpio_o, 0);
    chk("rst_mid_fall", fall_o, 0);
    chk("rst_mid_rise", rise_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    rd(20'h00, v); chk("rst_mid_thr", v, 32'h3E8);

    // randomized traffic
    repeat (4000) begin
      @(negedge clk_i);
      sys_wen = 0; sys_ren = 0;
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 11) == 0)
          gpio_i[i] = ~gpio_i[i];
      rst_i = ($urandom_range(0, 999) == 0);
      r = $urandom_range(0, 11);
      sys_addr = $urandom() & 32'hFFF0_0000;
      sys_wdata = $urandom();
      case (r)
        0: begin
          sys_addr[19:0] = 20'h00;
          sys_wdata = $urandom_range(0, 6);
          sys_wen = 1;
        end
        1, 2, 3, 4: begin
          sys_addr[19:0] = alist[r];
          sys_wen = 1;
        end
        5, 6: begin
          sys_addr[19:0] = alist[$urandom_range(0, 8)];
          sys_ren = 1;
        end
        7: begin
          sys_addr[19:0] = 20'h7C;
          sys_wen = 1;
        end
        default: ;
      endcase
    end
    @(negedge clk_i);
    sys_wen = 0; sys_ren = 0; rst_i = 0;
    repeat (4) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
